// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose:
//   Bundles the fetch-side, data-side and shared-memory signals of the
//   memory port arbiter into one interface. The arbiter connects through
//   the slave modport. Whatever surrounds it (fetch unit, load/store unit,
//   memory and main control) connects through the master modport.
//
// Signal summary:
//   halt_sys     control -> arbiter  blocks new grants while high
//   if_req       fetch   -> arbiter  fetch request (held until if_ack)
//   if_addr[16]  fetch   -> arbiter  fetch address
//   if_ack       arbiter -> fetch    one-cycle completion pulse
//   if_rdata[16] arbiter -> fetch    last fetched instruction word
//   d_req        data    -> arbiter  data request (held until d_ack)
//   d_we         data    -> arbiter  1 = write, 0 = read
//   d_addr[16]   data    -> arbiter  data address
//   d_wdata[16]  data    -> arbiter  write data
//   d_ack        arbiter -> data     one-cycle completion pulse
//   d_rdata[16]  arbiter -> data     last data read word
//   mem_en       arbiter -> memory   one-cycle access strobe
//   mem_we       arbiter -> memory   write enable
//   mem_addr[16] arbiter -> memory   access address
//   mem_wdata[16]arbiter -> memory   write data
//   mem_rdata[16]memory  -> arbiter  read data, valid MEM_LAT cycles after mem_en
//   stall_fetch  arbiter -> hazard   fetch must hold its PC
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        halt_sys;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_ack;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        stall_fetch;

    // Arbiter side
    modport slave (
        input  halt_sys, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall_fetch
    );

    // Requesters, memory and control side
    modport master (
        output halt_sys, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall_fetch
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported memory between instruction fetch and the data
//   (load/store) side. The arbiter grants one requester per transaction and
//   runs the transaction as IDLE -> WAIT (MEM_LAT cycles) -> DONE. On the
//   grant it registers the address, write enable and write data. In DONE it
//   pulses the winner's ack. Data beats fetch on a tie.
//
// Parameters:
//   MEM_LAT     cycles from mem_en to valid mem_rdata (1..7)
//   STARVE_MAX  data grants allowed while fetch waits (1..15); used only
//               when MEM_ARB_FAIRNESS_EN is defined
//
// Build option:
//   MEM_ARB_FAIRNESS_EN  when defined, a 4-bit starvation counter forces a
//                        fetch grant after STARVE_MAX consecutive data grants
//                        while fetch is waiting. When undefined, data always
//                        wins.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  mem_port_arbiter_if.slave (requests, acks, memory port, stall_fetch)
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    // Reject illegal parameter values at elaboration.
    generate
        if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_mem_lat
            $error("mem_port_arbiter: MEM_LAT must be 1..7");
        end
        if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
            $error("mem_port_arbiter: STARVE_MAX must be 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // The wait counter runs 0 .. MEM_LAT-1, so MEM_LAT = 7 still fits in 3 bits.
    localparam logic [2:0] LAST_CNT = 3'(MEM_LAT - 1);

    state_t      state_q,      state_d;
    logic [2:0]  cnt_q,        cnt_d;
    logic        grant_data_q, grant_data_d;
    logic        mem_en_q,     mem_en_d;
    logic        mem_we_q,     mem_we_d;
    logic [15:0] mem_addr_q,   mem_addr_d;
    logic [15:0] mem_wdata_q,  mem_wdata_d;
    logic        if_ack_q,     if_ack_d;
    logic        d_ack_q,      d_ack_d;
    logic [15:0] if_rdata_q,   if_rdata_d;
    logic [15:0] d_rdata_q,    d_rdata_d;

    logic        grant_fire;
    logic        pick_data;

    // A grant can happen only in IDLE, when control is not halting and
    // someone is asking.
    assign grant_fire = (state_q == IDLE) && !bus.halt_sys && (bus.d_req || bus.if_req);

`ifdef MEM_ARB_FAIRNESS_EN
    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [3:0] starve_q, starve_d;
    logic       fetch_turn;

    // Fetch takes its turn once data has won STARVE_LIMIT grants in a row
    // against a waiting fetch.
    assign fetch_turn = bus.if_req && (starve_q == STARVE_LIMIT);
    assign pick_data  = bus.d_req && !fetch_turn;

    // Count data grants made while fetch waits. Clear the count when fetch
    // wins or stops asking. While fetch_turn is set, data cannot win, so the
    // counter never passes STARVE_LIMIT.
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req) begin
            starve_d = 4'd0;
        end else if (grant_fire) begin
            if (pick_data) begin
                starve_d = starve_q + 4'd1;
            end else begin
                starve_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Strict priority: data always wins, and fetch can wait indefinitely.
    assign pick_data = bus.d_req;
`endif

    // State and datapath registers. Reset drops any in-flight transaction,
    // so no ack is issued for it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            grant_data_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            if_ack_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            if_rdata_q   <= 16'h0000;
            d_rdata_q    <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_data_q <= grant_data_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_ack_q     <= if_ack_d;
            d_ack_q      <= d_ack_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Next-state and output logic. mem_we, mem_addr and mem_wdata hold their
    // values until the next grant, so they stay stable through WAIT and DONE.
    // The read data registers are loaded only when a read completes on their
    // own side.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_data_d = grant_data_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_ack_d     = 1'b0;
        d_ack_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    state_d  = WAIT;
                    cnt_d    = 3'd0;
                    mem_en_d = 1'b1;
                    if (pick_data) begin
                        grant_data_d = 1'b1;
                        mem_we_d     = bus.d_we;
                        mem_addr_d   = bus.d_addr;
                        mem_wdata_d  = bus.d_wdata;
                    end else begin
                        grant_data_d = 1'b0;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = bus.if_addr;
                        mem_wdata_d  = 16'h0000;
                    end
                end
            end

            WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = 3'd0;
                    if (grant_data_q) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.if_ack      = if_ack_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_rdata     = d_rdata_q;

    // Fetch holds its PC from the moment it asks until its ack arrives.
    assign bus.stall_fetch = bus.if_req & ~if_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Directed, self-checking bench for mem_port_arbiter with MEM_LAT=1 and
//   STARVE_MAX=3. A small memory model answers reads from mem_addr and
//   commits writes on the clock edge where mem_en and mem_we are both high.
//   Expected grant order depends on MEM_ARB_FAIRNESS_EN.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic model_load;
    int   compare_count;
    int   mismatch_count;

    logic [15:0] mem_model [0:255];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MEM_LAT    (1),
        .STARVE_MAX (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with a 10-time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model. The preload values sit in distinct low-address-byte slots.
    always @(posedge clk) begin
        if (model_load) begin
            for (int i = 0; i < 256; i++) begin
                mem_model[i] <= 16'h0000;
            end
            mem_model[8'h00] <= 16'h5A01;
            mem_model[8'h10] <= 16'hA5A5;
            mem_model[8'h40] <= 16'h0F0F;
        end else if (bus.mem_en && bus.mem_we) begin
            mem_model[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    assign bus.mem_rdata = mem_model[bus.mem_addr[7:0]];

    // Count one comparison, and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive both requesters' inputs at once.
    task automatic applyStimulus(input logic ifr, input logic [15:0] ia,
                                 input logic dr, input logic dw,
                                 input logic [15:0] da, input logic [15:0] dwd);
        bus.if_req  = ifr;
        bus.if_addr = ia;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
    endtask

    // Move past the next rising edge and settle 1 unit after it.
    task automatic advanceCycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] grant_order;
    logic [7:0] expected_order;
    int         grant_count;
    int         cycle_count;

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        rst            = 1'b1;
        model_load     = 1'b1;
        bus.halt_sys   = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);

        repeat (2) advanceCycle();
        model_load = 1'b0;

        // Reset state
        checkOutput("rst_mem_en",    32'(bus.mem_en),    32'h0);
        checkOutput("rst_mem_we",    32'(bus.mem_we),    32'h0);
        checkOutput("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        checkOutput("rst_mem_wdata", 32'(bus.mem_wdata), 32'h0);
        checkOutput("rst_acks",      32'({bus.if_ack, bus.d_ack}), 32'h0);
        checkOutput("rst_if_rdata",  32'(bus.if_rdata),  32'h0);
        checkOutput("rst_d_rdata",   32'(bus.d_rdata),   32'h0);
        rst = 1'b0;

        // Single fetch: one-cycle mem_en, ack after WAIT, stall until ack
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        checkOutput("f_stall_pre",   32'(bus.stall_fetch), 32'h1);
        advanceCycle();
        checkOutput("f_mem_en",      32'(bus.mem_en),    32'h1);
        checkOutput("f_mem_addr",    32'(bus.mem_addr),  32'h0010);
        checkOutput("f_mem_we",      32'(bus.mem_we),    32'h0);
        checkOutput("f_stall_wait",  32'(bus.stall_fetch), 32'h1);
        advanceCycle();
        checkOutput("f_if_ack",      32'(bus.if_ack),    32'h1);
        checkOutput("f_if_rdata",    32'(bus.if_rdata),  32'hA5A5);
        checkOutput("f_mem_en_off",  32'(bus.mem_en),    32'h0);
        checkOutput("f_stall_ack",   32'(bus.stall_fetch), 32'h0);
        applyStimulus(1'b0, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000);
        advanceCycle();
        checkOutput("f_if_ack_off",  32'(bus.if_ack),    32'h0);
        advanceCycle();
        checkOutput("f_idle_no_en",  32'(bus.mem_en),    32'h0);
        checkOutput("f_rdata_hold",  32'(bus.if_rdata),  32'hA5A5);

        // Simultaneous requests: data first, fetch in the IDLE after DONE
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000);
        advanceCycle();
        checkOutput("sim_d_grant",   32'(bus.mem_en),    32'h1);
        checkOutput("sim_d_addr",    32'(bus.mem_addr),  32'h0200);
        advanceCycle();
        checkOutput("sim_d_ack",     32'({bus.d_ack, bus.if_ack}), 32'h2);
        checkOutput("sim_d_rdata",   32'(bus.d_rdata),   32'h5A01);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0200, 16'h0000);
        advanceCycle();
        checkOutput("sim_done_idle", 32'({bus.mem_en, bus.d_ack}), 32'h0);
        advanceCycle();
        checkOutput("sim_f_grant",   32'(bus.mem_en),    32'h1);
        checkOutput("sim_f_addr",    32'(bus.mem_addr),  32'h0010);
        advanceCycle();
        checkOutput("sim_f_ack",     32'(bus.if_ack),    32'h1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        advanceCycle();

        // Data write leaves d_rdata alone, then read back what was written
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 16'h1234);
        advanceCycle();
        checkOutput("wr_mem_en",     32'(bus.mem_en),    32'h1);
        checkOutput("wr_mem_we",     32'(bus.mem_we),    32'h1);
        checkOutput("wr_mem_addr",   32'(bus.mem_addr),  32'h0040);
        checkOutput("wr_mem_wdata",  32'(bus.mem_wdata), 32'h1234);
        advanceCycle();
        checkOutput("wr_d_ack",      32'(bus.d_ack),     32'h1);
        checkOutput("wr_we_stable",  32'(bus.mem_we),    32'h1);
        checkOutput("wr_rdata_keep", 32'(bus.d_rdata),   32'h5A01);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        advanceCycle();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
        advanceCycle();
        checkOutput("rb_mem_we",     32'(bus.mem_we),    32'h0);
        advanceCycle();
        checkOutput("rb_d_ack",      32'(bus.d_ack),     32'h1);
        checkOutput("rb_d_rdata",    32'(bus.d_rdata),   32'h1234);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        advanceCycle();

        // halt_sys raised during WAIT: the ack still arrives, then no grants
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, 16'h0000);
        advanceCycle();
        checkOutput("halt_d_grant",  32'(bus.mem_addr),  32'h0200);
        bus.halt_sys = 1'b1;
        advanceCycle();
        checkOutput("halt_d_ack",    32'(bus.d_ack),     32'h1);
        checkOutput("halt_d_rdata",  32'(bus.d_rdata),   32'h5A01);
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0200, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            advanceCycle();
            checkOutput("halt_no_grant", 32'(bus.mem_en), 32'h0);
        end
        checkOutput("halt_stall",    32'(bus.stall_fetch), 32'h1);
        bus.halt_sys = 1'b0;
        advanceCycle();
        checkOutput("halt_resume",   32'({bus.mem_en, bus.mem_addr}), 32'h10010);
        advanceCycle();
        checkOutput("halt_f_ack",    32'(bus.if_ack),    32'h1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        advanceCycle();

        // Reset during WAIT: no ack, outputs cleared, then a clean restart
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 16'h0000);
        advanceCycle();
        checkOutput("mid_grant",     32'(bus.mem_en),    32'h1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_bus",   32'({bus.mem_en, bus.mem_we, bus.mem_addr}), 32'h0);
        checkOutput("mid_rst_wdata", 32'(bus.mem_wdata), 32'h0);
        checkOutput("mid_rst_rdata", 32'({bus.if_rdata, bus.d_rdata}), 32'h0);
        checkOutput("mid_rst_acks",  32'({bus.if_ack, bus.d_ack}), 32'h0);
        advanceCycle();
        checkOutput("mid_rst_noack", 32'({bus.d_ack, bus.mem_en}), 32'h0);
        rst = 1'b0;
        advanceCycle();
        checkOutput("post_rst_grant", 32'({bus.mem_en, bus.mem_addr}), 32'h10040);
        advanceCycle();
        checkOutput("post_rst_ack",  32'(bus.d_ack),     32'h1);
        checkOutput("post_rst_data", 32'(bus.d_rdata),   32'h1234);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        advanceCycle();

        // Both requests held high: the grant order shows the priority rule
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0300, 16'h0000);
        grant_order = 8'h00;
        grant_count = 0;
        cycle_count = 0;
        while (grant_count < 8 && cycle_count < 60) begin
            advanceCycle();
            cycle_count++;
            if (bus.mem_en) begin
                grant_order[grant_count] = (bus.mem_addr != 16'h0300);
                grant_count++;
            end
        end
`ifdef MEM_ARB_FAIRNESS_EN
        expected_order = 8'h88;
`else
        expected_order = 8'h00;
`endif
        checkOutput("order_count",   32'(grant_count),   32'd8);
        checkOutput("order_seq",     32'(grant_order),   32'(expected_order));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (4) advanceCycle();
        checkOutput("final_idle",    32'({bus.mem_en, bus.if_ack, bus.d_ack}), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
